niosii_system_sysid_checker: RTL and testbench
==============================================

// Module: niosII_system_sysid_checker
// PURPOSE
//  Avalon-MM read master that sequences the system-ID slave: reads the ID word (address 0),
//  then the timestamp word (address 1), and compares both against build-time expected values.
//  Sits beside the CPU so that a hardware/software image mismatch is flagged before boot release.
//  Raises one-cycle done with pass/fail status; guards against a hung fabric with a read timeout.
// PARAMETERS
//  EXP_ID         32'h0000_0000  expected ID word
//  EXP_TIMESTAMP  32'd1490127728 expected timestamp word
//  TIMEOUT_CYC    256            max cycles per read from issue to readdatavalid (>=2)
//  AUTO_START     1              1: start one check automatically on the first cycle after reset
// PORTS
//  clock               in   1   system clock
//  reset_n             in   1   synchronous reset, active low
//  start               in   1   pulse: begin a check (ignored while busy)
//  avm_address         out  1   0 = ID word, 1 = timestamp word
//  avm_read            out  1   read strobe, held until waitrequest low
//  avm_waitrequest     in   1   fabric stall
//  avm_readdata        in   32  read data, valid with readdatavalid
//  avm_readdatavalid   in   1   read response
//  busy                out  1   check in progress
//  done                out  1   one-cycle pulse at end of check
//  pass                out  1   sticky: last check matched both words
//  timeout_err         out  1   sticky: last check aborted by timeout
//  id_value            out  32  last ID word captured
//  ts_value            out  32  last timestamp word captured
// BEHAVIOUR
//  - Reset (reset_n low at posedge): state IDLE; all outputs 0; timeout counter 0; AUTO_START armed.
//  - FSM: IDLE -> ID_REQ -> ID_WAIT -> TS_REQ -> TS_WAIT -> FINISH -> IDLE.
//  - IDLE: start=1 (or armed AUTO_START) -> ID_REQ next cycle; busy=1 from that cycle; pass and
//    timeout_err clear on entry to ID_REQ.
//  - *_REQ: avm_read=1, avm_address constant; leave to *_WAIT on cycle where waitrequest=0.
//    Address/read must not change while waitrequest=1.
//  - *_WAIT: avm_read=0; capture readdata on readdatavalid into id_value/ts_value, advance.
//    readdatavalid in the same cycle the request is accepted is legal (zero-latency slave):
//    capture it and skip *_WAIT (REQ -> next REQ/FINISH directly).
//  - Timeout: counter clears on entry to each REQ, increments every cycle in REQ/WAIT; reaching
//    TIMEOUT_CYC-1 without response -> FINISH with timeout_err=1, pass=0; id/ts_value keep last
//    captured values. Late readdatavalid arriving after abort (in IDLE) is ignored.
//  - FINISH: done=1 for exactly one cycle, busy=0 same cycle; pass = (id_value==EXP_ID) &&
//    (ts_value==EXP_TIMESTAMP) && !timeout_err. Latency with zero-wait slave: start to done = 4 cycles.
//  - start asserted while busy or in FINISH: ignored, not queued.
//  - Reset mid-check: immediate return to IDLE, outstanding read abandoned, all outputs 0.
//  - Compare is exact 32-bit equality; no masking.
// CONFIGURATION
//  SYSID_RECHECK_EN defined: add parameter RECHECK_CYC (default 2**24); a free-running 32-bit
//  counter in IDLE re-launches a check every RECHECK_CYC cycles after the last done; a failing
//  recheck clears pass. Undefined: checks run only on start/AUTO_START; no counter logic present.
// STRUCTURE
//  - Package niosII_system_sysid_pkg: state enum typedef, SYSID_ADDR_ID=1'b0, SYSID_ADDR_TS=1'b1.
//  - One sub-module: niosII_system_sysid_timeout (loadable down-counter, clear/enable, expire flag);
//    FSM, capture registers and comparator stay in the top.
// TESTING
//  1 Zero-latency slave returning 0 / 1490127728, AUTO_START=1 -> done at cycle 4, pass=1, ts_value=1490127728.
//  2 Slave returns ID 32'h0000_0001 -> done, pass=0, timeout_err=0, id_value=1.
//  3 waitrequest high 5 cycles on ID read -> avm_address/avm_read stable all 5, pass=1, done at cycle 9.
//  4 TIMEOUT_CYC=16, readdatavalid never asserted -> done 16 cycles after ID_REQ, timeout_err=1, pass=0.
//  5 reset_n low for 1 cycle during TS_WAIT -> next cycle all outputs 0, state IDLE; start -> clean pass.
//  6 SYSID_RECHECK_EN, RECHECK_CYC=100 -> second done 100 cycles after first; change ts to 0 -> pass drops to 0.

Source files
------------

// File: rtl/niosii_system_sysid_pkg.sv
// System-ID checker shared types.
// State encoding and slave word addresses.
package niosii_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_FINISH
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/niosii_system_sysid_timeout.sv
// Per-read watchdog: loadable down-counter.
// Ports: clock, reset_n (sync, low), load, en -> expire.
module niosii_system_sysid_timeout #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  // Loaded value expires so the abort edge is the one on
  // which an up-count from 0 would reach TIMEOUT_CYC-1.
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 2);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = LOAD_VAL;
    else if (en && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM master that reads sysid ID/timestamp and compares.
// Ports: clock, reset_n (sync, low), start; avm_* read master;
//   busy, done (pulse), pass, timeout_err, id_value, ts_value.
// Option: SYSID_RECHECK_EN adds periodic re-check (RECHECK_CYC).
module niosii_system_sysid_checker
  import niosii_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXP_ID        = 32'h0000_0000,
  parameter logic [31:0] EXP_TIMESTAMP = 32'd1490127728,
  parameter int unsigned TIMEOUT_CYC   = 256,
  parameter bit          AUTO_START    = 1'b1
`ifdef SYSID_RECHECK_EN
  ,
  parameter int unsigned RECHECK_CYC   = 2**24
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        tm_load;
  logic        tm_en;
  logic        tm_expire;
  logic        go;

`ifdef SYSID_RECHECK_EN
  logic [31:0] rc_q, rc_d;
  logic        ran_q, ran_d;

  // Launch lands 4 cycles before the target so the
  // zero-wait done falls RECHECK_CYC after the last one.
  localparam logic [31:0] RC_FIRE = 32'(RECHECK_CYC - 4);

  always_comb begin
    rc_d  = (state_q == ST_IDLE) ? rc_q + 32'd1 : 32'd0;
    ran_d = ran_q | (state_q == ST_FINISH);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rc_q  <= '0;
      ran_q <= 1'b0;
    end else begin
      rc_q  <= rc_d;
      ran_q <= ran_d;
    end
  end

  assign go = start | armed_q | (ran_q & (rc_q == RC_FIRE));
`else
  assign go = start | armed_q;
`endif

  niosii_system_sysid_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_tmo (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (tm_load),
    .en      (tm_en),
    .expire  (tm_expire)
  );

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    read_d  = read_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    tmo_d   = tmo_q;
    id_d    = id_q;
    ts_d    = ts_q;
    tm_load = 1'b0;
    tm_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_ID_REQ;
          armed_d = 1'b0;
          read_d  = 1'b1;
          addr_d  = SYSID_ADDR_ID;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          tmo_d   = 1'b0;
          tm_load = 1'b1;
        end
      end
      ST_ID_REQ: begin
        tm_en = 1'b1;
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) begin
            // zero-latency slave: go straight to next read
            id_d    = avm_readdata;
            state_d = ST_TS_REQ;
            addr_d  = SYSID_ADDR_TS;
            tm_load = 1'b1;
          end else begin
            state_d = ST_ID_WAIT;
            read_d  = 1'b0;
          end
        end else if (tm_expire) begin
          state_d = ST_FINISH;
          read_d  = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      ST_ID_WAIT: begin
        tm_en = 1'b1;
        if (avm_readdatavalid) begin
          id_d    = avm_readdata;
          state_d = ST_TS_REQ;
          read_d  = 1'b1;
          addr_d  = SYSID_ADDR_TS;
          tm_load = 1'b1;
        end else if (tm_expire) begin
          state_d = ST_FINISH;
          tmo_d   = 1'b1;
        end
      end
      ST_TS_REQ: begin
        tm_en = 1'b1;
        if (!avm_waitrequest) begin
          read_d = 1'b0;
          if (avm_readdatavalid) begin
            ts_d    = avm_readdata;
            state_d = ST_FINISH;
          end else begin
            state_d = ST_TS_WAIT;
          end
        end else if (tm_expire) begin
          state_d = ST_FINISH;
          read_d  = 1'b0;
          tmo_d   = 1'b1;
        end
      end
      ST_TS_WAIT: begin
        tm_en = 1'b1;
        if (avm_readdatavalid) begin
          ts_d    = avm_readdata;
          state_d = ST_FINISH;
        end else if (tm_expire) begin
          state_d = ST_FINISH;
          tmo_d   = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        addr_d  = SYSID_ADDR_ID;
        pass_d  = (id_q == EXP_ID) &&
                  (ts_q == EXP_TIMESTAMP) && !tmo_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      armed_q <= AUTO_START;
      read_q  <= 1'b0;
      addr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tmo_q   <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      read_q  <= read_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      tmo_q   <= tmo_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout_err = tmo_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the sysid checker.
// Drives a behavioural sysid slave with stall/latency knobs.
module tb_niosii_system_sysid_checker;

  localparam logic [31:0] TS = 32'd1490127728;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  logic [31:0] id_word;
  logic [31:0] ts_word;
  logic        rdv_en;
  logic        ts_hold;
  logic        rdv_force;
  int          wr_req;
  int          wr_used = 0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          t0;
  int          t1;
  int          t2;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  assign avm_waitrequest = avm_read && !avm_address &&
                           (wr_used < wr_req);

  always @(posedge clock)
    if (avm_waitrequest) wr_used <= wr_used + 1;

  assign avm_readdata = avm_address ? ts_word : id_word;
  assign avm_readdatavalid =
    (avm_read && !avm_waitrequest && rdv_en &&
     !(avm_address && ts_hold)) || rdv_force;

  niosii_system_sysid_checker #(
    .EXP_ID        (32'h0000_0000),
    .EXP_TIMESTAMP (TS),
    .TIMEOUT_CYC   (16),
    .AUTO_START    (1'b1)
`ifdef SYSID_RECHECK_EN
    ,
    .RECHECK_CYC   (100)
`endif
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .timeout_err       (timeout_err),
    .id_value          (id_value),
    .ts_value          (ts_value)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic launch();
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_done(output int t);
    bit seen;
    seen = 1'b0;
    t = cyc;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        t = cyc;
      end
    end
    if (!seen) check("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_tmo"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    check({tag, "_addr"}, {31'd0, avm_address}, 32'd0);
    check({tag, "_id"}, id_value, 32'd0);
    check({tag, "_ts"}, ts_value, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    id_word   = 32'd0;
    ts_word   = TS;
    rdv_en    = 1'b1;
    ts_hold   = 1'b0;
    rdv_force = 1'b0;
    wr_req    = 0;

    // 1: reset state, then AUTO_START with zero-wait slave
    repeat (3) @(negedge clock);
    check_zero("rst");
    reset_n = 1'b1;
    t0 = cyc;
    wait_done(t1);
    check("t1_lat", t1 - t0, 32'd4);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_ts", ts_value, TS);
    check("t1_tmo", {31'd0, timeout_err}, 32'd0);
    @(negedge clock);
    check("t1_pulse", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // 2: wrong ID word
    id_word = 32'd1;
    launch();
    wait_done(t1);
    check("t2_lat", t1 - t0, 32'd4);
    check("t2_pass", {31'd0, pass}, 32'd0);
    check("t2_tmo", {31'd0, timeout_err}, 32'd0);
    check("t2_id", id_value, 32'd1);

    // 4: no response -> timeout, captured words kept
    rdv_en = 1'b0;
    launch();
    wait_done(t1);
    check("t4_lat", t1 - t0, 32'd17);
    check("t4_tmo", {31'd0, timeout_err}, 32'd1);
    check("t4_pass", {31'd0, pass}, 32'd0);
    check("t4_id", id_value, 32'd1);
    check("t4_ts", ts_value, TS);
    id_word = 32'hDEAD_BEEF;
    rdv_force = 1'b1;
    @(negedge clock);
    rdv_force = 1'b0;
    @(negedge clock);
    check("t4_late_id", id_value, 32'd1);
    check("t4_late_busy", {31'd0, busy}, 32'd0);

    // 3: five stall cycles on ID read, start while busy
    rdv_en  = 1'b1;
    id_word = 32'd0;
    wr_req  = wr_used + 5;
    launch();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_wr", {31'd0, avm_waitrequest}, 32'd1);
      check("t3_rd", {31'd0, avm_read}, 32'd1);
      check("t3_ad", {31'd0, avm_address}, 32'd0);
      start = (i == 2);
    end
    start = 1'b0;
    wait_done(t1);
    check("t3_lat", t1 - t0, 32'd9);
    check("t3_pass", {31'd0, pass}, 32'd1);
    check("t3_tmo", {31'd0, timeout_err}, 32'd0);
    repeat (2) @(negedge clock);
    check("t3_noq", {31'd0, busy}, 32'd0);

    // 5: reset during TS_WAIT, then clean check
    ts_hold = 1'b1;
    launch();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (busy && avm_address && !avm_read) break;
    end
    check("t5_tswait", {30'd0, avm_address, avm_read},
          32'd2);
    reset_n = 1'b0;
    @(negedge clock);
    check_zero("t5rst");
    reset_n = 1'b1;
    ts_hold = 1'b0;
    start   = 1'b1;
    t0 = cyc;
    wait_done(t1);
    check("t5_lat", t1 - t0, 32'd4);
    check("t5_pass", {31'd0, pass}, 32'd1);
    check("t5_ts", ts_value, TS);

`ifdef SYSID_RECHECK_EN
    // 6: periodic recheck, then failing recheck
    wait_done(t2);
    check("t6_period", t2 - t1, 32'd100);
    check("t6_pass", {31'd0, pass}, 32'd1);
    ts_word = 32'd0;
    wait_done(t2);
    check("t6_fail", {31'd0, pass}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
